// File: rtl/bus_dma_master_if.sv
// Master-side bus bundle for bus_dma_master: request/grant handshake plus address and data paths.
interface bus_dma_master_if #(
   parameter int DATA_W = 64,
   parameter int ADDR_W = 16
);
   logic              m_req;
   logic              m_wr;
   logic [ADDR_W-1:0] m_addr;
   logic [DATA_W-1:0] m_dout;
   logic              m_grant;
   logic [DATA_W-1:0] m_din;

   modport master (output m_req, m_wr, m_addr, m_dout, input  m_grant, m_din);
   modport slave  (input  m_req, m_wr, m_addr, m_dout, output m_grant, m_din);
endinterface

// File: rtl/bus_dma_master.sv
// Word-copy DMA initiator: reads LEN words from src, writes them to dst, one read/write pair per word.
// Optional start-time range rejection is compiled in with `define DMA_RANGE_CHK_EN.
module bus_dma_master #(
   parameter int DATA_W = 64,
   parameter int ADDR_W = 16,
   parameter int LEN_W  = 8
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               start,
   input  logic [ADDR_W-1:0]  src_addr,
   input  logic [ADDR_W-1:0]  dst_addr,
   input  logic [LEN_W-1:0]   len,
   bus_dma_master_if.master   bus,
   output logic               busy,
   output logic               done,
   output logic               err
);
   typedef enum logic [2:0] {S_IDLE, S_REQ, S_RD_A, S_RD_D, S_WR, S_FIN} state_t;

   localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
   localparam logic [LEN_W-1:0]  LEN_ONE  = 1;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] src_q, src_d;
   logic [ADDR_W-1:0] dst_q, dst_d;
   logic [LEN_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] buf_q, buf_d;
   logic              reject;

`ifdef DMA_RANGE_CHK_EN
   localparam logic [ADDR_W:0] EXT_ONE = 1;
   logic [ADDR_W:0] src_end, dst_end;
   logic            err_q;

   // Last word address computed one bit wider; a set MSB means the range runs past the top.
   assign src_end = {1'b0, src_addr} + (ADDR_W+1)'(len) - EXT_ONE;
   assign dst_end = {1'b0, dst_addr} + (ADDR_W+1)'(len) - EXT_ONE;
   assign reject  = src_end[ADDR_W] | dst_end[ADDR_W];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) err_q <= 1'b0;
      else          err_q <= (state_q == S_IDLE) && start && (len != '0) && reject;
   end
   assign err = err_q;
`else
   assign reject = 1'b0;
   assign err    = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         src_q   <= '0;
         dst_q   <= '0;
         cnt_q   <= '0;
         buf_q   <= '0;
      end else begin
         state_q <= state_d;
         src_q   <= src_d;
         dst_q   <= dst_d;
         cnt_q   <= cnt_d;
         buf_q   <= buf_d;
      end
   end

   always_comb begin
      state_d = state_q;
      src_d   = src_q;
      dst_d   = dst_q;
      cnt_d   = cnt_q;
      buf_d   = buf_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (len == '0) begin
                  state_d = S_FIN;
               end else if (!reject) begin
                  src_d   = src_addr;
                  dst_d   = dst_addr;
                  cnt_d   = len;
                  state_d = S_REQ;
               end
            end
         end
         S_REQ:  if (bus.m_grant) state_d = S_RD_A;
         S_RD_A: if (bus.m_grant) state_d = S_RD_D;
         S_RD_D: begin
            buf_d   = bus.m_din;
            state_d = S_WR;
         end
         // A stalled write leaves pointers and count untouched so the word is retried verbatim.
         S_WR: begin
            if (bus.m_grant) begin
               src_d   = src_q + ADDR_ONE;
               dst_d   = dst_q + ADDR_ONE;
               cnt_d   = cnt_q - LEN_ONE;
               state_d = (cnt_q == LEN_ONE) ? S_FIN : S_RD_A;
            end
         end
         S_FIN:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      bus.m_req  = 1'b0;
      bus.m_wr   = 1'b0;
      bus.m_addr = '0;
      bus.m_dout = '0;
      busy       = (state_q != S_IDLE);
      done       = (state_q == S_FIN);
      case (state_q)
         S_REQ: bus.m_req = 1'b1;
         S_RD_A, S_RD_D: begin
            bus.m_req  = 1'b1;
            bus.m_addr = src_q;
         end
         S_WR: begin
            bus.m_req  = 1'b1;
            bus.m_wr   = 1'b1;
            bus.m_addr = dst_q;
            bus.m_dout = buf_q;
         end
         default: ;
      endcase
   end
endmodule

// File: tb/tb_bus_dma_master.sv
// Randomized bench for bus_dma_master: memory slave, sequential-copy reference model, directed corner cases.
module tb_bus_dma_master;
   localparam int DW = 64;
   localparam int AW = 16;
   localparam int LW = 8;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          start;
   logic [AW-1:0] src_addr, dst_addr;
   logic [LW-1:0] len;
   logic          busy, done, err;

   bus_dma_master_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

   bus_dma_master #(.DATA_W(DW), .ADDR_W(AW), .LEN_W(LW)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .start    (start),
      .src_addr (src_addr),
      .dst_addr (dst_addr),
      .len      (len),
      .bus      (bus),
      .busy     (busy),
      .done     (done),
      .err      (err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] a;
      logic [63:0] d;
   } wr_t;

   bit [63:0]   mem     [0:65535];
   bit [63:0]   ref_mem [0:65535];
   wr_t         wr_log[$];
   wr_t         exp_wr[$];
   bit          fill_req;
   int unsigned fill_seed;
   int          n_cmp = 0;
   int          n_err = 0;
   logic [63:0] t3_res [0:3];

   function automatic bit [63:0] pat(int unsigned s, int unsigned a);
      if (a == 0) return 64'hDEADBEEF_01234567;
      return {(s * 32'h9E3779B1) ^ (a * 32'h85EBCA6B), ((a + s) * 32'hC2B2AE35) ^ 32'h27D4EB2F};
   endfunction

   task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Memory slave: read data registered one cycle after the address, writes on granted write cycles.
   always @(posedge clk) begin
      if (fill_req) begin
         for (int a = 0; a < 65536; a++) mem[a] <= pat(fill_seed, a);
      end else begin
         bus.m_din <= mem[bus.m_addr];
         if (bus.m_req && bus.m_grant && bus.m_wr) begin
            mem[bus.m_addr] <= bus.m_dout;
            wr_log.push_back(wr_t'{bus.m_addr, bus.m_dout});
         end
      end
   end

   task automatic refill(int unsigned seed);
      @(negedge clk);
      fill_seed = seed;
      fill_req  = 1'b1;
      for (int a = 0; a < 65536; a++) ref_mem[a] = pat(seed, a);
      @(negedge clk);
      fill_req = 1'b0;
   endtask

   // Reference: words copied strictly in order, one at a time, addresses wrapping at 16 bits.
   task automatic model_copy(logic [15:0] s, logic [15:0] d, int n);
      logic [15:0] as, ad;
      for (int i = 0; i < n; i++) begin
         as = s + 16'(i);
         ad = d + 16'(i);
         exp_wr.push_back(wr_t'{ad, ref_mem[as]});
         ref_mem[ad] = ref_mem[as];
      end
   endtask

   // mode 0: grant always high, 1: random stalls, 2: stalls at cycles 1-3 and 7-8 after start.
   task automatic run_xfer(string tag, logic [15:0] s, logic [15:0] d, logic [7:0] n,
                           int mode, int exp_cyc);
      int cyc, done_cyc, err_seen, req_drop;
      bit req_seen, rej;
      rej = 1'b0;
`ifdef DMA_RANGE_CHK_EN
      rej = (n != 0) && ((int'(s) + int'(n) - 1 > 65535) || (int'(d) + int'(n) - 1 > 65535));
`endif
      wr_log.delete();
      exp_wr.delete();
      if (!rej) model_copy(s, d, int'(n));
      @(negedge clk);
      chk({tag, "_idle_busy"}, busy, 1'b0);
      src_addr = s; dst_addr = d; len = n; start = 1'b1;
      bus.m_grant = (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
      cyc = 0; done_cyc = -1; err_seen = 0; req_drop = 0; req_seen = 1'b0;
      while (cyc < 3000) begin
         @(negedge clk);
         cyc++;
         if (bus.m_req) req_seen = 1'b1;
         if (err) err_seen++;
         if (busy && !done && !bus.m_req) req_drop++;
         if (done) begin
            done_cyc = cyc;
            break;
         end
         if (rej && cyc == 4) break;
         start = 1'b0;
         if (cyc == 2 && busy) begin
            start = 1'b1; src_addr = 16'($urandom); dst_addr = 16'($urandom); len = 8'($urandom);
         end
         case (mode)
            0:       bus.m_grant = 1'b1;
            1:       bus.m_grant = ($urandom_range(0, 3) != 0);
            default: bus.m_grant = !(cyc inside {1, 2, 3, 7, 8});
         endcase
      end
      start = 1'b0;
      bus.m_grant = 1'b1;
      if (rej) begin
         chk({tag, "_err_pulses"}, 64'(err_seen), 64'd1);
         chk({tag, "_rej_req"}, req_seen, 1'b0);
         chk({tag, "_rej_done"}, 64'(done_cyc), 64'(-1));
      end else begin
         if (exp_cyc >= 0) chk({tag, "_done_cycle"}, 64'(done_cyc), 64'(exp_cyc));
         else              chk({tag, "_done_seen"}, done_cyc > 0, 1'b1);
         chk({tag, "_req_seen"}, req_seen, n != 0);
         chk({tag, "_req_continuous"}, 64'(req_drop), 64'd0);
         chk({tag, "_err"}, 64'(err_seen), 64'd0);
      end
      chk({tag, "_write_count"}, 64'(wr_log.size()), 64'(exp_wr.size()));
      for (int i = 0; i < wr_log.size() && i < exp_wr.size(); i++) begin
         chk($sformatf("%s_wr%0d_addr", tag, i), wr_log[i].a, exp_wr[i].a);
         chk($sformatf("%s_wr%0d_data", tag, i), wr_log[i].d, exp_wr[i].d);
      end
      @(negedge clk);
      chk({tag, "_done_one_cycle"}, done, 1'b0);
      chk({tag, "_busy_cleared"}, busy, 1'b0);
      $display("xfer %s src=%h dst=%h len=%0d mode=%0d done_cycle=%0d writes=%0d",
               tag, s, d, n, mode, done_cyc, wr_log.size());
   endtask

   initial begin
      logic [15:0] rs, rd;
      logic [7:0]  rn;
      int          rm;
      reset_n = 1'b0; start = 1'b0; src_addr = '0; dst_addr = '0; len = '0;
      bus.m_grant = 1'b0; fill_req = 1'b0; fill_seed = 0;
      repeat (3) @(negedge clk);
      chk("rst_req", bus.m_req, 1'b0);
      chk("rst_wr", bus.m_wr, 1'b0);
      chk("rst_addr", bus.m_addr, 16'h0);
      chk("rst_dout", bus.m_dout, 64'h0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_err", err, 1'b0);
      reset_n = 1'b1;
      refill(1);

      run_xfer("T2", 16'h0000, 16'h0100, 8'd1, 0, 5);
      chk("T2_data", mem[16'h0100], 64'hDEADBEEF_01234567);
      run_xfer("T3", 16'h0010, 16'h0110, 8'd4, 0, 14);
      for (int i = 0; i < 4; i++) t3_res[i] = mem[16'h0110 + i];
      refill(1);
      run_xfer("T5", 16'h0010, 16'h0110, 8'd4, 2, 19);
      for (int i = 0; i < 4; i++) chk($sformatf("T5_vs_T3_%0d", i), mem[16'h0110 + i], t3_res[i]);
      run_xfer("T4", 16'h0020, 16'h0120, 8'd0, 0, 1);
      run_xfer("T6", 16'hFFFF, 16'h0200, 8'd2, 0, 8);
`ifndef DMA_RANGE_CHK_EN
      chk("T6_wrap_word", mem[16'h0201], 64'hDEADBEEF_01234567);
`endif

      for (int t = 0; t < 24; t++) begin
         rs = 16'($urandom);
         rd = 16'($urandom);
         if (t % 4 == 0) rs = 16'hFFFF - 16'($urandom_range(0, 3));
         rn = 8'($urandom_range(0, 8));
         rm = $urandom_range(0, 1);
         run_xfer($sformatf("R%0d", t), rs, rd, rn, rm,
                  (rm == 1) ? -1 : ((rn == 0) ? 1 : 2 + 3 * int'(rn)));
      end

      // Asynchronous reset in the middle of a burst.
      refill(2);
      @(negedge clk);
      src_addr = 16'h0040; dst_addr = 16'h0140; len = 8'd8; start = 1'b1; bus.m_grant = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      chk("T1_busy_before", busy, 1'b1);
      #2 reset_n = 1'b0;
      #1;
      chk("T1_req", bus.m_req, 1'b0);
      chk("T1_wr", bus.m_wr, 1'b0);
      chk("T1_addr", bus.m_addr, 16'h0);
      chk("T1_dout", bus.m_dout, 64'h0);
      chk("T1_busy", busy, 1'b0);
      chk("T1_done", done, 1'b0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("T1_idle_busy", busy, 1'b0);
      chk("T1_idle_req", bus.m_req, 1'b0);
      refill(3);
      run_xfer("T1_after", 16'h0300, 16'h0400, 8'd3, 0, 11);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
